// File: rtl/seg7_frame_decoder.sv
// Purpose: decode {a..g} segment beats to BCD and assemble NUM_DIGITS-digit frames (HEX_DECODE_EN adds A..F).
// Latency: out_valid rises 1 cycle after the beat that completes the frame is accepted.
// Backpressure: seg_ready is low while a frame is held; it returns 1 cycle after out_valid & out_ready.
module seg7_frame_decoder #(
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [6:0]              seg_in,
   input  logic                    seg_sof,
   input  logic                    seg_valid,
   output logic                    seg_ready,
   output logic [4*NUM_DIGITS-1:0] bcd_out,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    frame_err,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sync_err
);

   localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

`ifdef HEX_DECODE_EN
   localparam logic HEX_EN = 1'b1;
`else
   localparam logic HEX_EN = 1'b0;
`endif

   typedef enum logic {COLLECT, HOLD} state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           count, count_nxt;
   logic [4*NUM_DIGITS-1:0] shadow_bcd, shadow_bcd_nxt;
   logic [NUM_DIGITS-1:0]   shadow_err, shadow_err_nxt;
   logic                    accept, store, sync_nxt, done;
   logic                    known, is_hex, bad;
   logic [3:0]              nib;
   int                      pos;

   assign accept = seg_valid & seg_ready;

   // Exact-match segment decode; anything unknown becomes nibble F with an error flag
   always_comb begin
      nib    = 4'hF;
      is_hex = 1'b0;
      known  = 1'b1;
      case (seg_in)
         7'b1111110: nib = 4'h0;
         7'b0110000: nib = 4'h1;
         7'b1101101: nib = 4'h2;
         7'b1111001: nib = 4'h3;
         7'b0110011: nib = 4'h4;
         7'b1011011: nib = 4'h5;
         7'b1011111: nib = 4'h6;
         7'b1110000: nib = 4'h7;
         7'b1111111: nib = 4'h8;
         7'b1111011: nib = 4'h9;
         7'b1110111: begin nib = 4'hA; is_hex = 1'b1; end
         7'b0011111: begin nib = 4'hB; is_hex = 1'b1; end
         7'b1001110: begin nib = 4'hC; is_hex = 1'b1; end
         7'b0111101: begin nib = 4'hD; is_hex = 1'b1; end
         7'b1001111: begin nib = 4'hE; is_hex = 1'b1; end
         7'b1000111: begin nib = 4'hF; is_hex = 1'b1; end
         default:    known = 1'b0;
      endcase
      bad = !known || (is_hex && !HEX_EN);
      if (bad) nib = 4'hF;
   end

   // Next-state: framing decisions, shadow write position and frame completion
   always_comb begin
      state_nxt      = state;
      count_nxt      = count;
      shadow_bcd_nxt = shadow_bcd;
      shadow_err_nxt = shadow_err;
      sync_nxt       = 1'b0;
      done           = 1'b0;
      store          = 1'b0;
      pos            = int'(count);
      if (state == COLLECT) begin
         if (accept) begin
            if (seg_sof) begin
               // A new SOF restarts the frame; a non-empty partial frame is a framing error
               sync_nxt       = (count != '0);
               shadow_err_nxt = '0;
               pos            = 0;
               store          = 1'b1;
            end else if (count == '0) begin
               sync_nxt = 1'b1;
            end else begin
               store = 1'b1;
            end
            if (store) begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (pos == i) begin
                     shadow_bcd_nxt[4*(NUM_DIGITS-1-i) +: 4] = nib;
                     shadow_err_nxt[NUM_DIGITS-1-i]          = bad;
                  end
               end
               if (pos == NUM_DIGITS-1) begin
                  done      = 1'b1;
                  state_nxt = HOLD;
                  count_nxt = '0;
               end else begin
                  count_nxt = CW'(pos + 1);
               end
            end
         end
      end else begin
         if (out_ready) state_nxt = COLLECT;
      end
   end

   // State, digit counter and shadow frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= COLLECT;
         count      <= '0;
         shadow_bcd <= '0;
         shadow_err <= '0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         shadow_bcd <= shadow_bcd_nxt;
         shadow_err <= shadow_err_nxt;
      end
   end

   // Registered outputs; the visible frame only changes when a frame completes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg_ready <= 1'b1;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
         bcd_out   <= '0;
         digit_err <= '0;
         frame_err <= 1'b0;
      end else begin
         seg_ready <= (state_nxt == COLLECT);
         out_valid <= (state_nxt == HOLD);
         sync_err  <= sync_nxt;
         if (done) begin
            bcd_out   <= shadow_bcd_nxt;
            digit_err <= shadow_err_nxt;
            frame_err <= |shadow_err_nxt;
         end
      end
   end

endmodule

// File: doc/seg7_frame_decoder.md
Name: seg7_frame_decoder

Overview:
Receive side of the seven-segment display bus. Accepts a stream of {a,b,c,d,e,f,g} segment patterns, one digit per beat, using a valid/ready handshake with a start-of-frame marker. Decodes each pattern back to BCD and assembles NUM_DIGITS digits into one frame. Presents the frame on a held output with a valid/ready handshake, for use by the display loop-back checker and the counter readback path.

Parameters:
NUM_DIGITS, 4, digits per frame; legal range 1..8.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset.
seg_in  input  7  segment pattern; bit 6 = a, bit 0 = g; 1 = segment lit.
seg_sof  input  1  marks the first digit (MSD) of a frame; qualified by seg_valid.
seg_valid  input  1  seg_in/seg_sof valid this cycle.
seg_ready  output  1  decoder can accept a beat this cycle.
bcd_out  output  4*NUM_DIGITS  decoded frame; bits [4*NUM_DIGITS-1 -: 4] hold the first (MSD) digit.
digit_err  output  NUM_DIGITS  per-digit invalid-pattern flags; bit NUM_DIGITS-1 corresponds to the first digit.
frame_err  output  1  OR of digit_err.
out_valid  output  1  frame available.
out_ready  input  1  consumer accepts the frame.
sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (reset low, asynchronous):
  - state = COLLECT, digit count = 0.
  - bcd_out = 0, digit_err = 0, frame_err = 0, out_valid = 0, sync_err = 0.
  - seg_ready = 1. All outputs are registered.
- Beat acceptance: a beat is accepted on a posedge with seg_valid & seg_ready.
- Decode table (bus order a..g), exact match only:
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4.
  - 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9.
  - Any other pattern, including 0000001 (dash) and 0000000 (blank): store nibble 4'hF and set the matching digit_err bit.
- COLLECT state, seg_ready = 1:
  - Accepted beat with seg_sof while count = 0: store digit 0, clear all digit_err bits of the new frame, count = 1.
  - Accepted beat without seg_sof while count = 0: beat dropped, sync_err pulses on the next cycle, count stays 0.
  - Accepted beat with seg_sof while count > 0: partial frame discarded, sync_err pulses, and this beat becomes digit 0 (count = 1).
  - Accepted beat without seg_sof while count > 0: store at position count, then count++.
  - When the beat that completes digit NUM_DIGITS-1 is accepted:
    - next cycle: state = HOLD, out_valid = 1, seg_ready = 0, count = 0.
    - Latency: out_valid rises exactly 1 cycle after the final beat is accepted.
  - seg_sof while seg_valid = 0 is ignored.
- HOLD state:
  - bcd_out, digit_err and frame_err are stable.
  - Waits for out_valid & out_ready. On that handshake: next cycle out_valid = 0, seg_ready = 1, state = COLLECT.
  - A seg_valid beat in the same cycle as the output handshake is NOT accepted (seg_ready is 0 that cycle).
- bcd_out retains the last frame after out_valid drops, until the next frame completes.
  - Digits are written into a shadow register; bcd_out updates only on the transition into HOLD.
- NUM_DIGITS = 1: every accepted beat must carry seg_sof; each such beat completes a frame.
- Reset asserted mid-frame or in HOLD: everything returns to the reset values immediately; the partial or held frame is lost.

Optional Feature:
HEX_DECODE_EN
- Defined: the decode table additionally accepts A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - These decode to 4'hA..4'hF with no digit_err.
  - A digit_err digit still stores 4'hF, so consumers must use digit_err to tell it apart from a valid F.
- Not defined: those six patterns are invalid (nibble 4'hF, digit_err set).

Test Plan:
- Encode/decode round trip (NUM_DIGITS=4): send 1111110 with sof, then 0110000, 1101101, 1111001, with out_ready=1 → 1 cycle after the 4th beat: out_valid=1, bcd_out=16'h0123, digit_err=4'b0000, frame_err=0; seg_ready returns to 1 after the handshake.
- Invalid pattern: frame of 0, 1, 0000001, 3 → bcd_out=16'h01F3, digit_err=4'b0010, frame_err=1.
- Backpressure: frame of 9,8,7,6 with out_ready=0 for 10 cycles → out_valid and bcd_out=16'h9876 held; seg_ready=0 throughout; a seg_valid beat offered meanwhile is not consumed. Raise out_ready → out_valid falls next cycle.
- Resync: send 5, 5 (sof on the first), then sof with 2, then 4,6,8 → sync_err one pulse; frame bcd_out=16'h2468. Separately, a beat without sof at count 0 → dropped, sync_err pulse.
- Reset mid-frame: assert reset after 2 digits → all outputs immediately at reset values. Release reset and send a full frame of 1,2,3,4 → bcd_out=16'h1234.
- HEX_DECODE_EN: pattern 1001110 in digit 1 → with macro defined: nibble C, no error; without the macro: nibble F, digit_err bit 2 set.
